// File: rtl/nibble_alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// nibble_alu_arbiter_if
// Bundles the requester-side and ALU-side signals of the nibble ALU arbiter.
//   slave  modport : arbiter view (samples requests and ALU status, drives
//                    grants, done pulses, result and latched ALU operands)
//   master modport : environment view (requesters plus the ALU loop)
// Per-requester fields are packed, requester n occupying slice [n*width +: width].
// ---------------------------------------------------------------------------
interface nibble_alu_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int W      = 32,
  parameter int CTRL_W = 8
);
  // requester side
  logic [NREQ-1:0]        req;
  logic [NREQ*W-1:0]      req_w1;
  logic [NREQ*W-1:0]      req_w2;
  logic [NREQ*CTRL_W-1:0] req_ctrl;
  logic [NREQ*3-1:0]      req_nibbles;
  logic [NREQ*W-1:0]      req_preinit;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [W-1:0]           rsp_result;
  // ALU side
  logic                   alu_perm_to_count;
  logic [W-1:0]           alu_w1;
  logic [W-1:0]           alu_w2;
  logic [CTRL_W-1:0]      alu_ctrl;
  logic [2:0]             alu_nibbles;
  logic [W-1:0]           alu_preinit;
  logic                   alu_busy;
  logic [W-1:0]           alu_result;

  modport slave (
    input  req, req_w1, req_w2, req_ctrl, req_nibbles, req_preinit,
    input  alu_busy, alu_result,
    output gnt, done, rsp_result,
    output alu_perm_to_count, alu_w1, alu_w2, alu_ctrl, alu_nibbles, alu_preinit
  );

  modport master (
    output req, req_w1, req_w2, req_ctrl, req_nibbles, req_preinit,
    output alu_busy, alu_result,
    input  gnt, done, rsp_result,
    input  alu_perm_to_count, alu_w1, alu_w2, alu_ctrl, alu_nibbles, alu_preinit
  );
endinterface

// File: rtl/nibble_alu_arbiter.sv
// ---------------------------------------------------------------------------
// nibble_alu_arbiter
// Shares one nibble-serial ALU loop between NREQ requesters with round-robin
// arbitration; one operation in flight at a time.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high; aborts any operation without done
//   bus  : nibble_alu_arbiter_if.slave
//          req/req_* in   per-requester request and operands
//          gnt       out  one-hot owner of the ALU (ISSUE..DONE)
//          done      out  one-hot single-cycle result-valid pulse
//          rsp_result out result, held between operations
//          alu_*     out  operands latched on grant, stable until next grant
//          alu_busy/alu_result in  ALU loop status and result
// Sequence per operation: IDLE -> ISSUE -> RUN -> DONE -> IDLE (>= 4 cycles).
// ---------------------------------------------------------------------------
module nibble_alu_arbiter #(
  parameter int NREQ   = 2,
  parameter int W      = 32,
  parameter int CTRL_W = 8
) (
  input logic                clk,
  input logic                rst,
  nibble_alu_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_win;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [W-1:0]      r_rsp;
  logic [W-1:0]      r_alu_w1;
  logic [W-1:0]      r_alu_w2;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [2:0]        r_alu_nibbles;
  logic [W-1:0]      r_alu_preinit;

  // Unpacked per-requester views of the packed request buses.
  logic [W-1:0]      w_w1      [NREQ];
  logic [W-1:0]      w_w2      [NREQ];
  logic [CTRL_W-1:0] w_ctrl    [NREQ];
  logic [2:0]        w_nibbles [NREQ];
  logic [W-1:0]      w_preinit [NREQ];
  // w_cand[k] = requester index examined k-th, i.e. (r_ptr + k) mod NREQ.
  logic [PTR_W-1:0]  w_cand    [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [PTR_W:0] w_sum;
    assign w_w1[gi]      = bus.req_w1[gi*W +: W];
    assign w_w2[gi]      = bus.req_w2[gi*W +: W];
    assign w_ctrl[gi]    = bus.req_ctrl[gi*CTRL_W +: CTRL_W];
    assign w_nibbles[gi] = bus.req_nibbles[gi*3 +: 3];
    assign w_preinit[gi] = bus.req_preinit[gi*W +: W];
    assign w_sum         = {1'b0, r_ptr} + (PTR_W+1)'(gi);
    assign w_cand[gi]    = (w_sum >= (PTR_W+1)'(NREQ))
                           ? PTR_W'(w_sum - (PTR_W+1)'(NREQ))
                           : w_sum[PTR_W-1:0];
  end

  logic             w_any;
  logic [PTR_W-1:0] w_win;
  logic [NREQ-1:0]  w_win_onehot;
  logic             w_perm;

  // Scan candidates from farthest to nearest so the nearest set request,
  // starting at the round-robin pointer, overwrites the others.
  always_comb begin
    w_win = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[w_cand[k]]) w_win = w_cand[k];
    end
  end

  assign w_any        = |bus.req;
  assign w_win_onehot = NREQ'(1) << w_win;

  // Permission follows ALU busy directly in RUN so it drops in the same
  // cycle the loop reports completion; ISSUE covers the ALU's busy latency.
  assign w_perm = (r_state == ST_ISSUE) || ((r_state == ST_RUN) && bus.alu_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_win         <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_rsp         <= '0;
      r_alu_w1      <= '0;
      r_alu_w2      <= '0;
      r_alu_ctrl    <= '0;
      r_alu_nibbles <= '0;
      r_alu_preinit <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_alu_w1      <= w_w1[w_win];
            r_alu_w2      <= w_w2[w_win];
            r_alu_ctrl    <= w_ctrl[w_win];
            r_alu_nibbles <= w_nibbles[w_win];
            r_alu_preinit <= w_preinit[w_win];
            r_win         <= w_win;
            r_gnt         <= w_win_onehot;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!bus.alu_busy) begin
            r_rsp   <= bus.alu_result;
            r_done  <= r_gnt;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_gnt   <= '0;
          r_ptr   <= (r_win == PTR_W'(NREQ - 1)) ? '0 : r_win + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt               = r_gnt;
  assign bus.done              = r_done;
  assign bus.rsp_result        = r_rsp;
  assign bus.alu_perm_to_count = w_perm;
  assign bus.alu_w1            = r_alu_w1;
  assign bus.alu_w2            = r_alu_w2;
  assign bus.alu_ctrl          = r_alu_ctrl;
  assign bus.alu_nibbles       = r_alu_nibbles;
  assign bus.alu_preinit       = r_alu_preinit;

endmodule

// File: tb/tb_nibble_alu_arbiter.sv
module tb_nibble_alu_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nibble_alu_arbiter_if #(.NREQ(2), .W(32), .CTRL_W(8)) bus ();

  nibble_alu_arbiter #(.NREQ(2), .W(32), .CTRL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: once permission is seen it stays busy for 'nibbles'
  // cycles, then reports w1 + w2.
  logic       m_started;
  logic [2:0] m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1'b0;
      m_cnt     <= 3'd0;
    end else if (bus.alu_perm_to_count && !m_started) begin
      m_started <= 1'b1;
      m_cnt     <= bus.alu_nibbles;
    end else begin
      if (m_cnt != 3'd0) m_cnt <= m_cnt - 3'd1;
      if (!bus.alu_perm_to_count) m_started <= 1'b0;
    end
  end
  assign bus.alu_busy   = (m_cnt != 3'd0);
  assign bus.alu_result = bus.alu_w1 + bus.alu_w2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [2:0] nib, input logic [7:0] ctrl, input logic [31:0] pre);
    bus.req_w1[r*32 +: 32]     = w1;
    bus.req_w2[r*32 +: 32]     = w2;
    bus.req_nibbles[r*3 +: 3]  = nib;
    bus.req_ctrl[r*8 +: 8]     = ctrl;
    bus.req_preinit[r*32 +: 32] = pre;
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.gnt == 2'b00 && n < 20);
    chk({tag, "_gnt_timeout"}, 64'(bus.gnt != 2'b00), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.done == 2'b00 && n < 20);
    chk({tag, "_done_timeout"}, 64'(bus.done != 2'b00), 64'd1);
    $display("op %s: gnt=%b done=%b rsp=%0h", tag, bus.gnt, bus.done, bus.rsp_result);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.req     = 2'b00;
    bus.req_w1  = '0;
    bus.req_w2  = '0;
    bus.req_ctrl = '0;
    bus.req_nibbles = '0;
    bus.req_preinit = '0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_gnt",  64'(bus.gnt), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_perm", 64'(bus.alu_perm_to_count), 64'd0);
    chk("rst_rsp",  64'(bus.rsp_result), 64'd0);
    chk("rst_w1",   64'(bus.alu_w1), 64'd0);

    // 1: single request, INCREMENT length
    set_op(0, 32'h0000_0AEF, 32'd4, 3'd0, 8'hA5, 32'h1234_5678);
    bus.req = 2'b01;
    step();
    chk("t1_gnt",     64'(bus.gnt), 64'h1);
    chk("t1_perm",    64'(bus.alu_perm_to_count), 64'd1);
    chk("t1_w1",      64'(bus.alu_w1), 64'h0AEF);
    chk("t1_ctrl",    64'(bus.alu_ctrl), 64'hA5);
    chk("t1_preinit", 64'(bus.alu_preinit), 64'h1234_5678);
    wait_done("t1");
    chk("t1_done",    64'(bus.done), 64'h1);
    chk("t1_rsp",     64'(bus.rsp_result), 64'h0AF3);
    chk("t1_gnt_dn",  64'(bus.gnt), 64'h1);
    bus.req = 2'b00;
    step();
    chk("t1_done_once", 64'(bus.done), 64'd0);
    chk("t1_gnt_drop",  64'(bus.gnt), 64'd0);
    chk("t1_rsp_hold",  64'(bus.rsp_result), 64'h0AF3);

    // 2: simultaneous requests straight from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 32'd1, 32'd1, 3'd1, 8'h00, 32'd0);
    set_op(1, 32'd10, 32'd5, 3'd1, 8'h00, 32'd0);
    bus.req = 2'b11;
    step();
    chk("t2_gnt0", 64'(bus.gnt), 64'h1);
    wait_done("t2a");
    chk("t2_done0", 64'(bus.done), 64'h1);
    chk("t2_rsp0",  64'(bus.rsp_result), 64'd2);
    bus.req = 2'b10;
    wait_gnt("t2b");
    chk("t2_gnt1", 64'(bus.gnt), 64'h2);
    wait_done("t2b");
    chk("t2_done1", 64'(bus.done), 64'h2);
    chk("t2_rsp1",  64'(bus.rsp_result), 64'd15);
    bus.req = 2'b00;
    step();

    // 3: both held for six operations; pointer left at 0 by test 2
    bus.req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_gnt("t3");
      chk($sformatf("t3_gnt%0d", i), 64'(bus.gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      wait_done($sformatf("t3_%0d", i));
      chk($sformatf("t3_done%0d", i), 64'(bus.done), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("t3_rsp%0d", i), 64'(bus.rsp_result), (i % 2 == 0) ? 64'd2 : 64'd15);
    end
    bus.req = 2'b00;
    step();

    // 4: requester 1, BITS_12; operands must not follow input changes
    set_op(1, 32'd123, 32'd2, 3'd2, 8'h3C, 32'd0);
    bus.req = 2'b10;
    wait_gnt("t4");
    chk("t4_gnt", 64'(bus.gnt), 64'h2);
    step();
    chk("t4_perm_run", 64'(bus.alu_perm_to_count), 64'd1);
    chk("t4_nib",      64'(bus.alu_nibbles), 64'd2);
    bus.req_w1[32 +: 32] = 32'd999;
    bus.req_w2[32 +: 32] = 32'd77;
    step();
    chk("t4_w1_stable", 64'(bus.alu_w1), 64'd123);
    chk("t4_w2_stable", 64'(bus.alu_w2), 64'd2);
    wait_done("t4");
    chk("t4_done", 64'(bus.done), 64'h2);
    chk("t4_rsp",  64'(bus.rsp_result), 64'd125);
    bus.req = 2'b00;
    step();

    // 5: reset during RUN aborts; then a fresh request is served
    set_op(0, 32'd7, 32'd8, 3'd7, 8'h00, 32'd0);
    bus.req = 2'b01;
    wait_gnt("t5");
    step();
    step();
    chk("t5_perm_run", 64'(bus.alu_perm_to_count), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 2'b00;
    chk("t5_gnt",  64'(bus.gnt), 64'd0);
    chk("t5_perm", 64'(bus.alu_perm_to_count), 64'd0);
    chk("t5_done", 64'(bus.done), 64'd0);
    chk("t5_w1",   64'(bus.alu_w1), 64'd0);
    set_op(1, 32'd20, 32'd22, 3'd1, 8'h00, 32'd0);
    bus.req = 2'b10;
    wait_gnt("t5b");
    chk("t5b_gnt", 64'(bus.gnt), 64'h2);
    wait_done("t5b");
    chk("t5b_done", 64'(bus.done), 64'h2);
    chk("t5b_rsp",  64'(bus.rsp_result), 64'd42);
    bus.req = 2'b00;
    step();

    // 6: requester drops req mid-operation; done still pulses once
    set_op(0, 32'd100, 32'd1, 3'd7, 8'h00, 32'd0);
    bus.req = 2'b01;
    wait_gnt("t6");
    chk("t6_gnt", 64'(bus.gnt), 64'h1);
    step();
    bus.req = 2'b00;
    wait_done("t6");
    chk("t6_done", 64'(bus.done), 64'h1);
    chk("t6_rsp",  64'(bus.rsp_result), 64'd101);
    step();
    chk("t6_done_once", 64'(bus.done), 64'd0);
    chk("t6_gnt_idle",  64'(bus.gnt), 64'd0);
    step();
    chk("t6_no_regrant", 64'(bus.gnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
